display_scanner: RTL and testbench

- Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display, with a free-running digit scan, dead-time blanking between digits and a scrolling message window.
- Sits between the message/character ROM (fed by char_idx) and the segment decoder and anode pins.
- Generalises the fixed 4-digit, externally counted anode driver: owns its scan counters, parametrised digit count, guard time and message length, with frame-synchronous scroll in both directions.

---
 rtl/display_scanner.sv | 72 +++++++
 tb/tb_display_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// display_scanner: multiplexed N-digit common-anode driver with guard-time blanking
// and a frame-synchronous scrolling message window.
module display_scanner #(
  parameter int DIGITS      = 4,
  parameter int SLOT_CYCLES = 16,
  parameter int GUARD       = 2,
  parameter int MSG_LEN     = 16,
  parameter int IDX_W       = $clog2(MSG_LEN),
  parameter int DSEL_W      = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              step,
  input  logic              dir,
  output logic [DIGITS-1:0] anodes,
  output logic [IDX_W-1:0]  char_idx,
  output logic [DSEL_W-1:0] digit_sel,
  output logic              frame_start
);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0]     WIN_LO     = SW'(GUARD);
  localparam logic [SW-1:0]     WIN_HI     = SW'(SLOT_CYCLES - 1 - GUARD);
  localparam logic [DSEL_W-1:0] DIGIT_LAST = DSEL_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(MSG_LEN - 1);
  localparam logic [IDX_W:0]    LEN        = (IDX_W+1)'(MSG_LEN);

  logic [SW-1:0]     slot, slot_n;
  logic [DSEL_W-1:0] digit, digit_n;
  logic [IDX_W-1:0]  start, start_n, idx_n;
  logic [IDX_W:0]    sum;
  logic [DIGITS-1:0] anodes_n;
  logic              pending, pending_n, slot_wrap, wrap;

  assign digit_sel = digit;

  // Outputs are computed from the next counter state so they line up with the counters.
  always_comb begin
    slot_wrap = slot == SLOT_LAST;
    wrap      = en && slot_wrap && digit == DIGIT_LAST;
    slot_n    = !en ? slot : slot_wrap ? '0 : slot + 1'b1;
    digit_n   = !(en && slot_wrap) ? digit : digit == DIGIT_LAST ? '0 : digit + 1'b1;
    start_n   = !(wrap && (pending || step)) ? start :
                dir ? (start == '0 ? IDX_LAST : start - 1'b1) :
                      (start == IDX_LAST ? '0 : start + 1'b1);
    pending_n = !wrap && (pending || step);
    sum       = {1'b0, start_n} + {{(IDX_W+1-DSEL_W){1'b0}}, DIGIT_LAST - digit_n};
    idx_n     = sum >= LEN ? IDX_W'(sum - LEN) : sum[IDX_W-1:0];
    anodes_n  = ~({{(DIGITS-1){1'b0}}, en && slot_n >= WIN_LO && slot_n <= WIN_HI} << digit_n);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot        <= '0;
      digit       <= '0;
      start       <= '0;
      pending     <= 1'b0;
      anodes      <= '1;
      char_idx    <= IDX_W'(DIGITS - 1);
      frame_start <= 1'b0;
    end else begin
      slot        <= slot_n;
      digit       <= digit_n;
      start       <= start_n;
      pending     <= pending_n;
      anodes      <= anodes_n;
      char_idx    <= idx_n;
      frame_start <= wrap;
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: table vectors, directed corner sequences and random stimulus
// checked against a frame-position reference model.
module tb_display_scanner;
  localparam int D = 4, S = 8, G = 2, L = 10, FRAME = D * S;

  logic       clk, reset_n, en, step, dir;
  logic [3:0] anodes;
  logic [3:0] char_idx;
  logic [1:0] digit_sel;
  logic       frame_start;

  display_scanner #(.DIGITS(D), .SLOT_CYCLES(S), .GUARD(G), .MSG_LEN(L)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .step(step), .dir(dir),
    .anodes(anodes), .char_idx(char_idx), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, max_idx = 0;
  int m_pos, m_start;
  logic m_pend, m_en_last, m_fs;

  typedef struct {
    logic en, step, dir;
    int reps;
    logic [3:0] an;
    int idx;
    logic fs;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_start = 0; m_pend = 0; m_en_last = 0; m_fs = 0;
  endtask

  function automatic logic [3:0] m_anodes();
    int dig = m_pos / S, sl = m_pos % S;
    return (m_en_last && sl >= G && sl <= S - 1 - G) ? ~(4'b0001 << dig) : 4'hF;
  endfunction

  function automatic int m_idx();
    return (m_start + D - 1 - m_pos / S) % L;
  endfunction

  // One clock: inputs set before the edge, model advanced at the edge, outputs checked 1 ns later.
  task automatic tick(input logic e, input logic s, input logic d);
    logic w;
    en = e; step = s; dir = d;
    @(posedge clk);
    w = e && m_pos == FRAME - 1;
    if (e) m_pos = (m_pos + 1) % FRAME;
    if (w) begin
      if (m_pend || s) m_start = d ? (m_start + L - 1) % L : (m_start + 1) % L;
      m_pend = 0;
    end else if (s) m_pend = 1;
    m_en_last = e; m_fs = w;
    #1;
    chk("anodes", anodes, m_anodes());
    chk("char_idx", char_idx, m_idx());
    chk("digit_sel", digit_sel, m_pos / S);
    chk("frame_start", frame_start, m_fs);
    if (char_idx > max_idx) max_idx = char_idx;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_anodes"}, anodes, 4'hF);
    chk({n, "_char_idx"}, char_idx, D - 1);
    chk({n, "_digit_sel"}, digit_sel, 0);
    chk({n, "_frame_start"}, frame_start, 0);
  endtask

  // Called between edges: reset must take effect before the next clock edge.
  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1 chk_reset("async_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    chk_reset("reset_hold");
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; step = 1'b0; dir = 1'b0;
    vt[0]  = '{1, 0, 0, 1, 4'hF, 3, 0};
    vt[1]  = '{1, 0, 0, 1, 4'hE, 3, 0};
    vt[2]  = '{1, 1, 0, 3, 4'hE, 3, 0};
    vt[3]  = '{1, 0, 0, 1, 4'hF, 3, 0};
    vt[4]  = '{1, 0, 0, 2, 4'hF, 2, 0};
    vt[5]  = '{1, 0, 0, 2, 4'hD, 2, 0};
    vt[6]  = '{1, 0, 0, 8, 4'hB, 1, 0};
    vt[7]  = '{1, 0, 0, 8, 4'h7, 0, 0};
    vt[8]  = '{1, 1, 0, 2, 4'h7, 0, 0};
    vt[9]  = '{1, 0, 0, 3, 4'hF, 0, 0};
    vt[10] = '{1, 0, 0, 1, 4'hF, 4, 1};
    vt[11] = '{1, 0, 0, 1, 4'hF, 4, 0};
    vt[12] = '{0, 1, 0, 5, 4'hF, 4, 0};
    vt[13] = '{1, 0, 0, 1, 4'hE, 4, 0};

    do_reset();
    foreach (vt[i]) begin
      repeat (vt[i].reps) tick(vt[i].en, vt[i].step, vt[i].dir);
      chk($sformatf("vec%0d_anodes", i), anodes, vt[i].an);
      chk($sformatf("vec%0d_char_idx", i), char_idx, vt[i].idx);
      chk($sformatf("vec%0d_frame_start", i), frame_start, vt[i].fs);
    end

    // Retreat from start 0 wraps to MSG_LEN-1.
    do_reset();
    tick(1, 1, 1);
    repeat (FRAME - 1) tick(1, 0, 1);
    chk("retreat_d0", char_idx, 2);
    repeat (S + 2) tick(1, 0, 1);
    chk("retreat_d1", char_idx, 1);
    repeat (S) tick(1, 0, 1);
    chk("retreat_d2", char_idx, 0);
    repeat (S) tick(1, 0, 1);
    chk("retreat_d3", char_idx, 9);

    // Ten single-step frames bring start back to 0.
    do_reset();
    max_idx = 0;
    for (int f = 0; f < L; f++) begin
      tick(1, 1, 0);
      repeat (FRAME - 1) tick(1, 0, 0);
    end
    chk("advance_full_lap", char_idx, 3);
    chk("advance_max_idx", max_idx, 9);

    // Freeze at digit 2 slot 3 with a step during the freeze.
    do_reset();
    repeat (2 * S + 3) tick(1, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, i == 5, 0);
    chk("freeze_anodes", anodes, 4'hF);
    chk("freeze_digit", digit_sel, 2);
    tick(1, 0, 0);
    chk("resume_anodes", anodes, 4'hB);
    repeat (FRAME - (2 * S + 4)) tick(1, 0, 0);
    chk("resume_scroll_idx", char_idx, 4);
    chk("resume_frame_start", frame_start, 1);

    // Reset with a pending step at digit 3 slot 4: the step is lost.
    tick(1, 1, 0);
    repeat (3 * S + 3) tick(1, 0, 0);
    chk("pre_reset_digit", digit_sel, 3);
    do_reset();
    repeat (FRAME) tick(1, 0, 0);
    chk("post_reset_no_scroll", char_idx, 3);
    chk("post_reset_frame_start", frame_start, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
